// File: rtl/config_bus_pkg.sv
// config_bus_pkg: shared bus field layout and FSM state encoding for the config bus master.
package config_bus_pkg;
    localparam int BUS_W    = 32;
    localparam int ADDR_LSB = 0;
    localparam int DATA_LSB = 16;
    localparam int WCLK_BIT = 24;
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among pending requests, starting one past the last accepted index.
//   clk, rst        : clock, async active-low reset (pointer returns to num_req-1)
//   i_req           : request vector
//   i_accept        : a grant was accepted this cycle
//   i_accept_idx    : index that was accepted; becomes the new last-grant pointer
//   o_grant, o_idx  : one-hot winner and its index (all zero when nothing pending)
module rr_arbiter #(
    parameter int num_req = 2,
    localparam int IW = num_req > 1 ? $clog2(num_req) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [num_req-1:0] i_req,
    input  logic               i_accept,
    input  logic [IW-1:0]      i_accept_idx,
    output logic [num_req-1:0] o_grant,
    output logic [IW-1:0]      o_idx
);
    logic [IW-1:0] r_last;
    logic [IW-1:0] w_j;
    logic          w_found;

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_last <= IW'(num_req - 1);
        else if (i_accept) r_last <= i_accept_idx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 1; k <= num_req; k++) begin
            w_j = IW'((int'(r_last) + k) % num_req);
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end
endmodule

// File: rtl/config_bus_master.sv
// config_bus_master: arbitrates requesters and serialises each write MSB-first onto the config bus.
//   clk, rst            : clock, async active-low reset
//   req_valid/req_ready : per-requester handshake; req_ready is a registered one-cycle accept pulse
//   req_addr/data/len   : per-requester payload, captured on accept
//   gpio_out            : [15:0] addr, [23:16] data, [24] w_clk, rest zero
//   busy, done, done_id : activity flag, completion pulse and the completing requester
module config_bus_master
    import config_bus_pkg::*;
#(
    parameter int num_req    = 2,
    parameter int max_words  = 4,
    parameter int strobe_cyc = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [num_req-1:0]           req_valid,
    output logic [num_req-1:0]           req_ready,
    input  logic [num_req*16-1:0]        req_addr,
    input  logic [num_req*max_words*8-1:0] req_data,
    input  logic [num_req*4-1:0]         req_len,
    output logic [BUS_W-1:0]             gpio_out,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   done_id
);
    localparam int DW = max_words * 8;
    localparam int IW = num_req > 1 ? $clog2(num_req) : 1;
    localparam int TW = strobe_cyc > 1 ? $clog2(strobe_cyc) : 1;

    state_t             r_state, w_next;
    logic [num_req-1:0] r_ready, w_grant;
    logic [IW-1:0]      r_gnt, w_idx;
    logic [15:0]        r_addr, w_addr;
    logic [DW-1:0]      r_data, w_data;
    logic [3:0]         r_cnt, w_len_raw, w_len;
    logic [TW-1:0]      r_tmr;
    logic               r_done;
    logic [2:0]         r_done_id;
    logic               w_acc, w_tend;

    rr_arbiter #(.num_req(num_req)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .i_req        (req_valid),
        .i_accept     (w_acc),
        .i_accept_idx (r_gnt),
        .o_grant      (w_grant),
        .o_idx        (w_idx)
    );

    // The registered ready pulse is only honoured if that requester is still valid.
    assign w_acc     = (r_state == IDLE) && |(r_ready & req_valid);
    assign w_addr    = req_addr[int'(r_gnt)*16 +: 16];
    assign w_data    = req_data[int'(r_gnt)*DW +: DW];
    assign w_len_raw = req_len[int'(r_gnt)*4 +: 4];
    assign w_len     = (w_len_raw > 4'(max_words)) ? 4'(max_words) : w_len_raw;
    assign w_tend    = r_tmr == TW'(strobe_cyc - 1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_acc ? ((w_len == 4'd0) ? DONE : SETUP) : IDLE;
            SETUP:   w_next = HIGH;
            HIGH:    w_next = w_tend ? LOW : HIGH;
            LOW:     w_next = w_tend ? ((r_cnt == 4'd1) ? DONE : SETUP) : LOW;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus is combinational from state so a reset drops w_clk without waiting for a clock.
    always_comb begin
        gpio_out = '0;
        if (r_state inside {SETUP, HIGH, LOW}) begin
            gpio_out[ADDR_LSB +: 16] = r_addr;
            gpio_out[DATA_LSB +: 8]  = r_data[DW-1 -: 8];
            gpio_out[WCLK_BIT]       = r_state == HIGH;
        end
        busy = (r_state != IDLE) || w_acc;
    end

    // Payload is left-aligned on capture so the byte on the bus is always the top byte.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_ready   <= '0;
            r_gnt     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_tmr     <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
        end else begin
            r_ready <= (w_next == IDLE) ? w_grant : '0;
            if (w_next == IDLE && |w_grant) r_gnt <= w_idx;
            r_done <= w_next == DONE;
            if (w_next == DONE) r_done_id <= 3'(r_gnt);
            r_tmr <= ((r_state == HIGH || r_state == LOW) && !w_tend) ? r_tmr + 1'b1 : '0;
            if (w_acc) begin
                r_addr <= w_addr;
                r_cnt  <= w_len;
                r_data <= w_data << (8 * (max_words - int'(w_len)));
            end else if (r_state == LOW && w_tend) begin
                r_cnt  <= r_cnt - 4'd1;
                r_data <= r_data << 8;
            end
        end

    assign req_ready = r_ready;
    assign done      = r_done;
    assign done_id   = r_done_id;
endmodule
